// File: rtl/cam_dvp_capture.sv
// DVP camera capture: packs bus words into pixels, crops to a window, drops
// startup frames and decimates frames. Runs entirely in the camera pclk domain.
module cam_dvp_capture #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned SKIP_FRAMES   = 10,
  parameter int unsigned H_START       = 0,
  parameter int unsigned H_SIZE        = 640,
  parameter int unsigned V_START       = 0,
  parameter int unsigned V_SIZE        = 480,
  parameter int unsigned FRAME_DECIM   = 0,
  parameter int unsigned CNT_W         = 12
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              cap_en,
  input  logic                              cam_vsync,
  input  logic                              cam_href,
  input  logic [DATA_W-1:0]                 cam_data,
  output logic                              pix_valid,
  output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data,
  output logic                              pix_sof,
  output logic                              pix_eol,
  output logic [15:0]                       frame_cnt,
  output logic                              byte_err
);

  localparam int unsigned      PIX_W     = DATA_W * BYTES_PER_PIX;
  localparam logic [1:0]       IDX_LAST  = 2'(BYTES_PER_PIX - 1);
  localparam logic [15:0]      SKIP_LAST = 16'(SKIP_FRAMES - 1);
  localparam logic [15:0]      DECIM_MAX = 16'(FRAME_DECIM);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {StIdle, StSkip, StWait, StCap} state_e;

  state_e state_q, state_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;

  logic              vs_q, vs_qq, hr_q, hr_qq;
  logic [DATA_W-1:0] data_q;
  logic              vs_fall, vs_rise, hr_fall;

  logic [1:0]       byte_idx_q;
  logic [PIX_W-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0] x_q, y_q, x_inc, y_inc;
  logic [15:0]      decim_cnt_q;
  logic             kept_q, sof_pend_q;
  logic             in_win, at_eol, frame_start;

  logic             pix_valid_q, pix_sof_q, pix_eol_q, byte_err_q;
  logic [PIX_W-1:0] pix_data_q;
  logic [15:0]      frame_cnt_q;

  // Register camera pins once; a second stage supplies edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_q   <= 1'b0;
      vs_qq  <= 1'b0;
      hr_q   <= 1'b0;
      hr_qq  <= 1'b0;
      data_q <= '0;
    end else begin
      vs_q   <= cam_vsync;
      vs_qq  <= vs_q;
      hr_q   <= cam_href;
      hr_qq  <= hr_q;
      data_q <= cam_data;
    end
  end

  assign vs_fall = vs_qq & ~vs_q;
  assign vs_rise = ~vs_qq & vs_q;
  assign hr_fall = hr_qq & ~hr_q;

  // FSM state and skip counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Next-state: skip startup frames, then align capture to a frame boundary.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cap_en) begin
          skip_cnt_d = '0;
          state_d    = (SKIP_FRAMES == 0) ? StWait : StSkip;
        end
      end
      StSkip: begin
        if (vs_fall) begin
          if (skip_cnt_q == SKIP_LAST) state_d = StCap;
          else                         skip_cnt_d = skip_cnt_q + 16'd1;
        end
      end
      StWait: begin
        if (vs_fall) state_d = StCap;
      end
      StCap: begin
        state_d = StCap;
      end
      default: state_d = StIdle;
    endcase
    if (!cap_en) state_d = StIdle;
  end

  // A frame starts on the vs_fall that lands in (or enters) capture.
  assign frame_start = vs_fall && (state_d == StCap);

  // Earlier bytes move toward the MSBs; truncation drops the previous pixel.
  assign shift_nxt = PIX_W'({shift_q, data_q});
  assign x_inc     = (x_q == CNT_MAX) ? x_q : x_q + 1'b1;
  assign y_inc     = (y_q == CNT_MAX) ? y_q : y_q + 1'b1;
  // Unsigned wrap makes columns left of the window compare out of range.
  assign in_win    = ((32'(x_q) - H_START) < H_SIZE) && ((32'(y_q) - V_START) < V_SIZE);
  assign at_eol    = (32'(x_q) == H_START + H_SIZE - 1);

  // Pixel packing, position tracking, frame keep/decimation and emission.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      byte_idx_q  <= '0;
      shift_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      decim_cnt_q <= '0;
      kept_q      <= 1'b0;
      sof_pend_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      frame_cnt_q <= '0;
      byte_err_q  <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      byte_err_q  <= 1'b0;
      if (state_q != StCap || !cap_en) begin
        byte_idx_q  <= '0;
        x_q         <= '0;
        y_q         <= '0;
        decim_cnt_q <= '0;
        kept_q      <= 1'b0;
        sof_pend_q  <= 1'b0;
      end else begin
        if (hr_q) begin
          shift_q <= shift_nxt;
          if (byte_idx_q == IDX_LAST) begin
            byte_idx_q <= '0;
            x_q        <= x_inc;
            if (kept_q && in_win) begin
              pix_valid_q <= 1'b1;
              pix_data_q  <= shift_nxt;
              pix_sof_q   <= sof_pend_q;
              pix_eol_q   <= at_eol;
              if (sof_pend_q) begin
                sof_pend_q  <= 1'b0;
                frame_cnt_q <= frame_cnt_q + 16'd1;
              end
            end
          end else begin
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        if (hr_fall) begin
          x_q        <= '0;
          byte_idx_q <= '0;
          y_q        <= y_inc;
          if (byte_idx_q != '0) byte_err_q <= 1'b1;
        end
        if (vs_rise) begin
          x_q        <= '0;
          y_q        <= '0;
          byte_idx_q <= '0;
        end
      end
      if (frame_start) begin
        kept_q      <= (decim_cnt_q == '0);
        sof_pend_q  <= (decim_cnt_q == '0);
        decim_cnt_q <= (decim_cnt_q == DECIM_MAX) ? '0 : decim_cnt_q + 16'd1;
        x_q         <= '0;
        y_q         <= '0;
        byte_idx_q  <= '0;
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_sof   = pix_sof_q;
  assign pix_eol   = pix_eol_q;
  assign frame_cnt = frame_cnt_q;
  assign byte_err  = byte_err_q;

endmodule
